// File: rtl/mips_cpu_sequencer_if.sv
// Sequencer-to-core bundle: instruction fetch port, decode feedback and stage enables.
// master = sequencer side, slave = memory/decode/datapath side.
interface mips_cpu_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              waitrequest;
    logic [31:0]       instr_readdata;
    logic              mem_op;
    logic              branch_valid;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic              fetch_en;
    logic              exec_en;
    logic              mem_en;
    logic              wb_en;
    logic              active;
    logic [31:0]       instr_count;
    logic [2:0]        state_dbg;

    modport master (
        input  waitrequest, instr_readdata, mem_op, branch_valid, branch_taken, branch_target,
        output pc, ir, fetch_en, exec_en, mem_en, wb_en, active, instr_count, state_dbg
    );

    modport slave (
        output waitrequest, instr_readdata, mem_op, branch_valid, branch_taken, branch_target,
        input  pc, ir, fetch_en, exec_en, mem_en, wb_en, active, instr_count, state_dbg
    );
endinterface

// File: rtl/mips_cpu_sequencer.sv
// Multicycle MIPS fetch/sequence unit: PC, IR, stage FSM, branch delay slot, halt on PC==HALT_ADDR.
// Optional retired-instruction counter enabled by defining MIPS_SEQ_INSTR_COUNT_EN.
module mips_cpu_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC0_0000),
    parameter logic [ADDR_W-1:0] HALT_ADDR    = '0,
    parameter int                BUS_MODE     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_enable,
    mips_cpu_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EXEC   = 3'd1,
        S_MEM    = 3'd2,
        S_WB     = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic              active_q;
    logic              delay_armed;
    logic              delay_pending;
    logic [ADDR_W-1:0] pending_target;
    logic              stall;

    // Handshake: fetch_en/mem_en is the request and waitrequest=1 means not ready; a transfer
    // completes on the enabled clock edge where the request is high and waitrequest is low.
    // With BUS_MODE=0 every request completes in the cycle it is made.
    assign stall = (BUS_MODE != 0) && bus.waitrequest;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_FETCH;
            pc_q           <= RESET_VECTOR;
            ir_q           <= '0;
            active_q       <= 1'b1;
            delay_armed    <= 1'b0;
            delay_pending  <= 1'b0;
            pending_target <= '0;
        end else if (clk_enable) begin
            case (state)
                S_FETCH: begin
                    if (pc_q == HALT_ADDR) begin
                        state    <= S_HALTED;
                        active_q <= 1'b0;
                    end else if (!stall) begin
                        ir_q  <= bus.instr_readdata;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A branch in a delay slot overwrites the pending target; undefined but terminates.
                    if (bus.branch_valid && bus.branch_taken) begin
                        pending_target <= {bus.branch_target[ADDR_W-1:2], 2'b00};
                        delay_armed    <= 1'b1;
                    end
                    state <= bus.mem_op ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (!stall) state <= S_WB;
                end
                S_WB: begin
                    if (delay_pending) pc_q <= pending_target;
                    else               pc_q <= pc_q + ADDR_W'(4);
                    // Armed at the branch's EXEC, promoted here, consumed at the delay slot's WB.
                    delay_pending <= delay_armed;
                    delay_armed   <= 1'b0;
                    state         <= S_FETCH;
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_HALTED;
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.ir        = ir_q;
    assign bus.active    = active_q;
    assign bus.state_dbg = state;
    assign bus.fetch_en  = !reset && (state == S_FETCH) && (pc_q != HALT_ADDR);
    assign bus.exec_en   = !reset && (state == S_EXEC);
    assign bus.mem_en    = !reset && (state == S_MEM);
    assign bus.wb_en     = !reset && (state == S_WB);

`ifdef MIPS_SEQ_INSTR_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clk_enable && (state == S_WB) && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign bus.instr_count = count_q;
`else
    assign bus.instr_count = 32'd0;
`endif
endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Bench for mips_cpu_sequencer: a Harvard instance and a bus instance run side by side against
// an architectural pc/npc reference model, plus directed timing, stall, halt and reset checks.
module tb_mips_cpu_sequencer;
    localparam logic [31:0] RV = 32'hBFC0_0000;

    // Per-cycle expectations for the stalled bus test: {fetch_en, exec_en, mem_en, wb_en}.
    localparam logic [3:0] T4_EN1 [10] = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h4, 4'h2, 4'h2, 4'h2, 4'h1, 4'h8};
    localparam logic       T4_WR  [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [3:0] T4_EN0 [5]  = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8};

    // clock/reset block
    logic clk = 1'b0;
    logic reset;
    logic clk_enable;
    always #5 clk = ~clk;

    mips_cpu_sequencer_if #(.ADDR_W(32)) bus0 ();
    mips_cpu_sequencer_if #(.ADDR_W(32)) bus1 ();

    mips_cpu_sequencer #(.ADDR_W(32), .RESET_VECTOR(RV), .HALT_ADDR(32'h0), .BUS_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(bus0)
    );
    mips_cpu_sequencer #(.ADDR_W(32), .RESET_VECTOR(RV), .HALT_ADDR(32'h0), .BUS_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(bus1)
    );

    // Program memory and decode: ir[0]=mem_op, ir[1]=branch_valid, ir[2]=branch_taken.
    logic [31:0] prog [256];
    logic [31:0] tgt  [256];
    logic [31:0] noise;
    logic [3:0]  en0, en1;

    always @(negedge clk) noise = $urandom();

    always_comb begin
        bus0.instr_readdata = prog[bus0.pc[9:2]];
        bus0.mem_op         = bus0.exec_en ? bus0.ir[0] : noise[0];
        bus0.branch_valid   = bus0.exec_en ? bus0.ir[1] : noise[1];
        bus0.branch_taken   = bus0.exec_en ? bus0.ir[2] : noise[2];
        bus0.branch_target  = bus0.exec_en ? (tgt[bus0.pc[9:2]] | {30'd0, noise[4:3]}) : noise;
        bus1.instr_readdata = prog[bus1.pc[9:2]];
        bus1.mem_op         = bus1.exec_en ? bus1.ir[0] : noise[5];
        bus1.branch_valid   = bus1.exec_en ? bus1.ir[1] : noise[6];
        bus1.branch_taken   = bus1.exec_en ? bus1.ir[2] : noise[7];
        bus1.branch_target  = bus1.exec_en ? (tgt[bus1.pc[9:2]] | {30'd0, noise[9:8]}) : ~noise;
    end

    assign en0 = {bus0.fetch_en, bus0.exec_en, bus0.mem_en, bus0.wb_en};
    assign en1 = {bus1.fetch_en, bus1.exec_en, bus1.mem_en, bus1.wb_en};

    // scoreboard state
    logic [63:0] exp_q0 [$];
    logic [63:0] exp_q1 [$];
    logic [31:0] mpc [2];
    logic [31:0] mnpc [2];
    int unsigned mcount [2];
    int unsigned retired [2];
    int unsigned checks = 0;
    int unsigned errors = 0;

    function automatic logic [31:0] exp_cnt(input int unsigned n);
`ifdef MIPS_SEQ_INSTR_COUNT_EN
        return n;
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Fetch acceptance issues the expected retirement; a wb_en cycle pops and compares it.
    task automatic observe(input int d, input logic fe, input logic stall, input logic we,
                           input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] cnt);
        logic [63:0] exp;
        logic [31:0] inst, nxt;
        logic [7:0]  idx;
        logic        empty;
        if (we) begin
            empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected dut%0d pc=%h expected no retirement", d, pc);
            end else begin
                if (d == 0) exp = exp_q0.pop_front();
                else        exp = exp_q1.pop_front();
                chk($sformatf("retire_pc_ir_dut%0d", d), {pc, ir}, exp);
            end
            chk($sformatf("retire_count_dut%0d", d), {32'd0, cnt}, {32'd0, exp_cnt(mcount[d])});
            mcount[d]++;
            retired[d]++;
        end
        if (fe && !stall) begin
            chk($sformatf("fetch_pc_dut%0d", d), {32'd0, pc}, {32'd0, mpc[d]});
            idx  = mpc[d][9:2];
            inst = prog[idx];
            if (d == 0) exp_q0.push_back({mpc[d], inst});
            else        exp_q1.push_back({mpc[d], inst});
            nxt     = mnpc[d];
            mnpc[d] = (inst[1] && inst[2]) ? {tgt[idx][31:2], 2'b00} : mnpc[d] + 32'd4;
            mpc[d]  = nxt;
        end
    endtask

    // monitor: samples one time unit before each rising edge
    always @(negedge clk) begin
        #4;
        if (!reset && clk_enable) begin
            observe(0, bus0.fetch_en, 1'b0, bus0.wb_en, bus0.pc, bus0.ir, bus0.instr_count);
            observe(1, bus1.fetch_en, bus1.waitrequest, bus1.wb_en, bus1.pc, bus1.ir, bus1.instr_count);
        end
    end

    // driver tasks
    task automatic load_plain();
        for (int i = 0; i < 256; i++) begin
            prog[i] = $urandom() & 32'hFFFF_FFF8;
            tgt[i]  = RV;
        end
    endtask

    task automatic load_random();
        logic [31:0] p;
        for (int i = 0; i < 256; i++) begin
            p = $urandom();
            if (i % 2 == 1) p[1] = 1'b0;
            prog[i] = p;
            tgt[i]  = RV | 32'($urandom_range(0, 1023));
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        clk_enable = 1'b1;
        @(negedge clk);
        exp_q0.delete();
        exp_q1.delete();
        for (int d = 0; d < 2; d++) begin
            mpc[d]     = RV;
            mnpc[d]    = RV + 32'd4;
            mcount[d]  = 0;
            retired[d] = 0;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc0"}, {32'd0, bus0.pc}, {32'd0, RV});
        chk({tag, "_pc1"}, {32'd0, bus1.pc}, {32'd0, RV});
        chk({tag, "_ir0"}, {32'd0, bus0.ir}, 64'd0);
        chk({tag, "_ir1"}, {32'd0, bus1.ir}, 64'd0);
        chk({tag, "_active0"}, {63'd0, bus0.active}, 64'd1);
        chk({tag, "_active1"}, {63'd0, bus1.active}, 64'd1);
        chk({tag, "_en0"}, {60'd0, en0}, 64'd0);
        chk({tag, "_en1"}, {60'd0, en1}, 64'd0);
        chk({tag, "_cnt0"}, {32'd0, bus0.instr_count}, 64'd0);
        chk({tag, "_cnt1"}, {32'd0, bus1.instr_count}, 64'd0);
    endtask

    logic [31:0] snap_pc0, snap_ir0, snap_cnt0, snap_pc1, snap_ir1, snap_cnt1;
    logic [2:0]  snap_st0, snap_st1;
    logic [31:0] t2_pc [3];

    initial begin
        clk_enable       = 1'b1;
        bus0.waitrequest = 1'b0;
        bus1.waitrequest = 1'b0;
        load_plain();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1 chk_reset_vals("reset_init");

        // Five plain instructions: FETCH, EXEC, WB each, pc steps by 4.
        load_plain();
        do_reset();
        #4;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) begin @(negedge clk); #4; end
            chk("plain_wb0", {63'd0, bus0.wb_en}, {63'd0, (c % 3 == 2)});
            chk("plain_wb1", {63'd0, bus1.wb_en}, {63'd0, (c % 3 == 2)});
            if (c % 3 == 0) begin
                chk("plain_pc0", {32'd0, bus0.pc}, {32'd0, RV + 32'(4 * (c / 3))});
                chk("plain_fetch0", {63'd0, bus0.fetch_en}, 64'd1);
            end
        end

        // Taken branch at RV to RV+0x100; the delay slot at RV+4 executes first.
        load_plain();
        prog[0] = ($urandom() & 32'hFFFF_FFF8) | 32'h6;
        tgt[0]  = 32'hBFC0_0103;
        t2_pc   = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0100};
        do_reset();
        #4;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin @(negedge clk); #4; end
            if (c % 3 == 0) begin
                chk("branch_pc0", {32'd0, bus0.pc}, {32'd0, t2_pc[c / 3]});
                chk("branch_pc1", {32'd0, bus1.pc}, {32'd0, t2_pc[c / 3]});
                chk("branch_fetch0", {63'd0, bus0.fetch_en}, 64'd1);
            end
        end

        // Jump to 0 with a delay slot: two retirements, then halt at pc 0.
        load_plain();
        prog[0] = ($urandom() & 32'hFFFF_FFF8) | 32'h6;
        tgt[0]  = 32'h0000_0002;
        do_reset();
        #4;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) begin @(negedge clk); #4; end
            if (c >= 6) begin
                chk("halt_pc0", {32'd0, bus0.pc}, 64'd0);
                chk("halt_pc1", {32'd0, bus1.pc}, 64'd0);
                chk("halt_fetch0", {63'd0, bus0.fetch_en}, 64'd0);
            end
            if (c >= 7) begin
                chk("halt_active0", {63'd0, bus0.active}, 64'd0);
                chk("halt_active1", {63'd0, bus1.active}, 64'd0);
                chk("halt_en0", {60'd0, en0}, 64'd0);
                chk("halt_en1", {60'd0, en1}, 64'd0);
            end
        end
        chk("halt_cnt0", {32'd0, bus0.instr_count}, {32'd0, exp_cnt(2)});
        chk("halt_cnt1", {32'd0, bus1.instr_count}, {32'd0, exp_cnt(2)});

        // Bus stalls: 3 waits in FETCH, 2 in MEM; the Harvard instance ignores waitrequest.
        load_plain();
        prog[0] = prog[0] | 32'h1;
        bus0.waitrequest = 1'b1;
        bus1.waitrequest = 1'b1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            bus1.waitrequest = T4_WR[c];
            #4;
            chk("stall_en1", {60'd0, en1}, {60'd0, T4_EN1[c]});
            chk("stall_ir1", {32'd0, bus1.ir}, (c < 4) ? 64'd0 : {32'd0, prog[0]});
            if (c < 5) chk("stall_en0", {60'd0, en0}, {60'd0, T4_EN0[c]});
        end
        chk("stall_pc1", {32'd0, bus1.pc}, {32'd0, RV + 32'd4});
        bus0.waitrequest = 1'b0;
        bus1.waitrequest = 1'b0;

        // clk_enable low for 4 cycles while both instances sit in EXEC.
        load_plain();
        do_reset();
        #4;
        @(negedge clk);
        clk_enable = 1'b0;
        #4;
        snap_pc0 = bus0.pc; snap_ir0 = bus0.ir; snap_cnt0 = bus0.instr_count; snap_st0 = bus0.state_dbg;
        snap_pc1 = bus1.pc; snap_ir1 = bus1.ir; snap_cnt1 = bus1.instr_count; snap_st1 = bus1.state_dbg;
        chk("freeze_exec0", {60'd0, en0}, 64'h4);
        chk("freeze_ir0", {32'd0, bus0.ir}, {32'd0, prog[0]});
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); #4;
            chk("freeze_pc0", {32'd0, bus0.pc}, {32'd0, snap_pc0});
            chk("freeze_ir0", {32'd0, bus0.ir}, {32'd0, snap_ir0});
            chk("freeze_st0", {61'd0, bus0.state_dbg}, {61'd0, snap_st0});
            chk("freeze_cnt0", {32'd0, bus0.instr_count}, {32'd0, snap_cnt0});
            chk("freeze_pc1", {32'd0, bus1.pc}, {32'd0, snap_pc1});
            chk("freeze_ir1", {32'd0, bus1.ir}, {32'd0, snap_ir1});
            chk("freeze_st1", {61'd0, bus1.state_dbg}, {61'd0, snap_st1});
            chk("freeze_cnt1", {32'd0, bus1.instr_count}, {32'd0, snap_cnt1});
        end
        @(negedge clk);
        clk_enable = 1'b1;
        #4 chk("resume_exec0", {60'd0, en0}, 64'h4);
        @(negedge clk); #4 chk("resume_wb0", {60'd0, en0}, 64'h1);
        @(negedge clk); #4 chk("resume_pc0", {32'd0, bus0.pc}, {32'd0, RV + 32'd4});
        chk("resume_pc1", {32'd0, bus1.pc}, {32'd0, RV + 32'd4});

        // Asynchronous reset while the bus instance is stalled in MEM.
        load_plain();
        prog[0] = prog[0] | 32'h1;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        bus1.waitrequest = 1'b1;
        #4 chk("areset_mem1", {60'd0, en1}, 64'h2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_vals("areset");
        bus1.waitrequest = 1'b0;

        // Randomized run: random programs, waitrequest and clk_enable.
        load_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            clk_enable       = ($urandom_range(0, 9) != 0);
            bus0.waitrequest = 1'($urandom_range(0, 1));
            bus1.waitrequest = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        #4;
        chk("random_retired0", {63'd0, retired[0] >= 100}, 64'd1);
        chk("random_retired1", {63'd0, retired[1] >= 100}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
